// File: rtl/alu_op_decoder_pkg.sv
// rtl/alu_op_decoder_pkg.sv - shared ALU op enum, RV32I opcode/funct constants and decoded bundle type
package alu_op_decoder_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SLL    = 4'd1,
        ALU_XOR    = 4'd2,
        ALU_SRL    = 4'd3,
        ALU_SRA    = 4'd4,
        ALU_OR     = 4'd5,
        ALU_AND    = 4'd6,
        ALU_SUB    = 4'd7,
        ALU_PASS_A = 4'd8,
        ALU_PASS_B = 4'd9
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_op_e     alu_op;
        logic        b_sel_imm;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_wr;
        logic        illegal;
    } dec_bundle_t;

    // slt/sltu share funct3 pattern 01x and are not supported by this ALU.
    function automatic logic is_slt(input logic [2:0] f3);
        return f3[2:1] == 2'b01;
    endfunction

    // Operation selected by funct3 when funct7 is the base encoding.
    function automatic alu_op_e f3_base_op(input logic [2:0] f3);
        alu_op_e op;
        op = ALU_ADD;
        case (f3)
            F3_SLL:     op = ALU_SLL;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = ALU_SRL;
            F3_OR:      op = ALU_OR;
            F3_AND:     op = ALU_AND;
            default:    op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_op_decode_comb.sv
// rtl/alu_op_decode_comb.sv - pure combinational RV32I instruction to ALU control decode
module alu_op_decode_comb
    import alu_op_decoder_pkg::*;
(
    input  logic [31:0] instr,
    output dec_bundle_t dec
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic [31:0] imm_shamt;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];
    assign imm_i     = {{20{instr[31]}}, instr[31:20]};
    assign imm_s     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_u     = {instr[31:12], 12'b0};
    assign imm_shamt = {27'b0, instr[24:20]};

    alu_op_e     op;
    logic        bsel;
    logic [31:0] imm_sel;
    logic        legal;
    logic        writes;

    always_comb begin
        op      = ALU_ADD;
        bsel    = 1'b0;
        imm_sel = '0;
        legal   = 1'b0;
        writes  = 1'b0;
        case (opcode)
            OPC_OP: begin
                legal  = ((funct7 == F7_BASE) && !is_slt(funct3)) ||
                         ((funct7 == F7_ALT) && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA)));
                op     = (funct7 == F7_ALT) ? ((funct3 == F3_ADD_SUB) ? ALU_SUB : ALU_SRA)
                                            : f3_base_op(funct3);
                writes = 1'b1;
            end
            OPC_OP_IMM: begin
                bsel   = 1'b1;
                writes = 1'b1;
                if ((funct3 == F3_SLL) || (funct3 == F3_SRL_SRA)) begin
                    // Shift immediates carry funct7 in the upper bits, so only shamt is the operand.
                    legal   = (funct7 == F7_BASE) || ((funct3 == F3_SRL_SRA) && (funct7 == F7_ALT));
                    op      = (funct7 == F7_ALT) ? ALU_SRA : f3_base_op(funct3);
                    imm_sel = imm_shamt;
                end else begin
                    legal   = !is_slt(funct3);
                    op      = f3_base_op(funct3);
                    imm_sel = imm_i;
                end
            end
            OPC_LUI: begin
                legal   = 1'b1;
                op      = ALU_PASS_B;
                bsel    = 1'b1;
                imm_sel = imm_u;
                writes  = 1'b1;
            end
            OPC_LOAD: begin
                legal   = 1'b1;
                bsel    = 1'b1;
                imm_sel = imm_i;
                writes  = 1'b1;
            end
            OPC_STORE: begin
                legal   = 1'b1;
                bsel    = 1'b1;
                imm_sel = imm_s;
            end
            default: legal = 1'b0;
        endcase

        dec.rs1       = instr[19:15];
        dec.rs2       = instr[24:20];
        dec.rd        = instr[11:7];
        dec.illegal   = !legal;
        dec.alu_op    = legal ? op : ALU_ADD;
        dec.b_sel_imm = legal && bsel;
        dec.imm       = legal ? imm_sel : '0;
        dec.reg_wr    = legal && writes && (instr[11:7] != 5'd0);
    end

endmodule

// File: rtl/alu_op_decoder.sv
// rtl/alu_op_decoder.sv - registered decode stage with valid/ready handshake and illegal counter
module alu_op_decoder
    import alu_op_decoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  alu_op,
    output logic        b_sel_imm,
    output logic [31:0] imm,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        reg_wr,
    output logic        illegal,
    output logic [7:0]  illegal_cnt
);

    dec_bundle_t dec_d;
    dec_bundle_t bundle_q;
    logic        valid_q;
    logic [7:0]  cnt_q;
    logic        in_fire;
    logic        out_fire;

    alu_op_decode_comb u_decode (
        .instr (instr),
        .dec   (dec_d)
    );

    // Single output register: a new word may enter whenever the current one leaves.
    assign in_ready = !valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = valid_q && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (in_fire) begin
                bundle_q <= dec_d;
                valid_q  <= 1'b1;
            end else if (out_fire) begin
                valid_q  <= 1'b0;
            end
            if (out_fire && bundle_q.illegal && (cnt_q != 8'hFF)) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign out_valid   = valid_q;
    assign alu_op      = bundle_q.alu_op;
    assign b_sel_imm   = bundle_q.b_sel_imm;
    assign imm         = bundle_q.imm;
    assign rs1         = bundle_q.rs1;
    assign rs2         = bundle_q.rs2;
    assign rd          = bundle_q.rd;
    assign reg_wr      = bundle_q.reg_wr;
    assign illegal     = bundle_q.illegal;
    assign illegal_cnt = cnt_q;

endmodule
